// File: rtl/conv_scan_ctrl.sv
// Raster-scan sequencer for the streaming convolution datapath: tracks pixel position,
// flags complete KxK windows and frames each image. Optional stall counter: CONV_SCAN_STALL_CNT_EN.
module conv_scan_ctrl #(
    parameter int unsigned K     = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] img_w,
    input  logic [CNT_W-1:0] img_h,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pix_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_row,
    output logic [CNT_W-1:0] out_col,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
`ifdef CONV_SCAN_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] K_SZ = CNT_W'(K);
    localparam logic [CNT_W-1:0] K_M1 = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_row_q, out_row_d;
    logic [CNT_W-1:0] out_col_q, out_col_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    logic start_ok;
    logic accept;
    logic col_last;
    logic last_pix;
    logic win_hit;

    // Handshake: a pixel may enter only when the output slot is free or draining this cycle
    assign start_ok = start && (img_w >= K_SZ) && (img_h >= K_SZ);
    assign in_ready = (state_q == ST_SCAN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pix_en   = accept;
    assign col_last = (col_q == (w_q - ONE));
    assign last_pix = col_last && (row_q == (h_q - ONE));
    assign win_hit  = accept && (row_q >= K_M1) && (col_q >= K_M1);

    // Next-state, counters and output stage
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        w_d         = w_q;
        h_d         = h_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        cfg_err_d   = cfg_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d   = ST_SCAN;
                    w_d       = img_w;
                    h_d       = img_h;
                    row_d     = '0;
                    col_d     = '0;
                    cfg_err_d = 1'b0;
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (accept) begin
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_q + ONE;
                    end else begin
                        col_d = col_q + ONE;
                    end
                    if (last_pix) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Consume and reload may coincide for one window per clock
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (win_hit) begin
            out_valid_d = 1'b1;
            out_row_d   = row_q - K_M1;
            out_col_d   = col_q - K_M1;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            w_q         <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            w_q         <= w_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

`ifdef CONV_SCAN_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating count of cycles where upstream offered a pixel but was back-pressured
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start_ok) begin
            stall_d = '0;
        end else if ((state_q == ST_SCAN) && in_valid && !in_ready && (stall_q != '1)) begin
            stall_d = stall_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Randomized self-checking bench for conv_scan_ctrl; expected window coordinates come from
// enumerating every KxK-complete pixel of the configured image in raster order.
module tb_conv_scan_ctrl;

    localparam int unsigned K    = 3;
    localparam int unsigned CW   = 16;
    localparam int          MAXC = 5000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] img_w;
    logic [CW-1:0] img_h;
    logic          in_valid;
    logic          in_ready;
    logic          pix_en;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          busy;
    logic          done;
    logic          cfg_err;
`ifdef CONV_SCAN_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    conv_scan_ctrl #(.K(K), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .img_w     (img_w),
        .img_h     (img_h),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix_en    (pix_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
`ifdef CONV_SCAN_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; img_w = '0; img_h = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || pix_en !== 1'b0 || out_valid !== 1'b0 || out_row !== '0 ||
            out_col !== '0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b pe=%b ov=%b r=%0d c=%0d busy=%b done=%b err=%b, required all 0",
                     in_ready, pix_en, out_valid, out_row, out_col, busy, done, cfg_err);
        end
`ifdef CONV_SCAN_STALL_CNT_EN
        n_tests++;
        if (stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_stall: got %0d required 0", stall_cnt);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full image run: vpct/rpct are in_valid/out_ready percentages; hold_first stalls the first
    // window 5 cycles; poke pulses start mid-scan; chk_timing checks the done latency.
    task automatic scan_image(input int w, input int h, input int vpct, input int rpct,
                              input bit hold_first, input bit poke, input bit chk_timing);
        int er[$];
        int ec[$];
        int accepts = 0, cyc = 0, stalls = 0, done_cnt = 0;
        int t_last = -1, t_done = -1, hold = 0;
        int xr, xc;
        bit scanning = 1'b1, held = 1'b0, prev_block = 1'b0;
        logic [CW-1:0] prev_r = '0, prev_c = '0;

        for (int r = K - 1; r < h; r++)
            for (int c = K - 1; c < w; c++) begin
                er.push_back(r - (K - 1));
                ec.push_back(c - (K - 1));
            end

        @(negedge clk);
        start = 1'b1; img_w = CW'(w); img_h = CW'(h); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; img_w = CW'($urandom); img_h = CW'($urandom);
        #1;
        n_tests++;
        if (busy !== 1'b1 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ack %0dx%0d: busy=%b cfg_err=%b, required busy=1 cfg_err=0", w, h, busy, cfg_err);
        end

        while (1) begin
            if (hold_first && !held && out_valid === 1'b1) begin
                held = 1'b1;
                hold = 5;
            end
            out_ready = (hold > 0) ? 1'b0 : ($urandom_range(99) < rpct);
            in_valid  = ($urandom_range(99) < vpct);
            start     = poke && (accepts == 3);
            if (start) begin
                img_w = CW'(3);
                img_h = CW'(3);
            end
            #1;
            if (hold > 0) begin
                n_tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_row !== '0 || out_col !== '0) begin
                    n_fail++;
                    $display("FAIL hold_stall: rdy=%b ov=%b coord=(%0d,%0d), required rdy=0 ov=1 (0,0)",
                             in_ready, out_valid, out_row, out_col);
                end
                hold--;
            end
            n_tests++;
            if (pix_en !== (in_valid & in_ready)) begin
                n_fail++;
                $display("FAIL pix_en: got %b required %b", pix_en, in_valid & in_ready);
            end
            if (scanning && in_valid && !in_ready) stalls++;
            if (prev_block) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_row !== prev_r || out_col !== prev_c) begin
                    n_fail++;
                    $display("FAIL out_stable: ov=%b (%0d,%0d), required ov=1 (%0d,%0d)",
                             out_valid, out_row, out_col, prev_r, prev_c);
                end
            end
            prev_block = (out_valid === 1'b1) && !out_ready;
            prev_r = out_row;
            prev_c = out_col;
            if (out_valid === 1'b1 && out_ready) begin
                n_tests++;
                if (er.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_window: got (%0d,%0d), required none", out_row, out_col);
                end else begin
                    xr = er.pop_front();
                    xc = ec.pop_front();
                    if (out_row !== CW'(xr) || out_col !== CW'(xc)) begin
                        n_fail++;
                        $display("FAIL window_coord: got (%0d,%0d) required (%0d,%0d)", out_row, out_col, xr, xc);
                    end
                end
            end
            if (pix_en === 1'b1) begin
                accepts++;
                if (accepts == w * h) begin
                    scanning = 1'b0;
                    t_last = cyc;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (t_done < 0) t_done = cyc;
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_at_done: got %b required 1", busy);
                end
            end
            if (t_done >= 0 && cyc == t_done + 1) begin
                n_tests++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_fall: busy=%b done=%b, required 0 0", busy, done);
                end
                break;
            end
            if (cyc >= MAXC) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout %0dx%0d: accepts=%0d done_cnt=%0d, required done within %0d cycles",
                         w, h, accepts, done_cnt, MAXC);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        n_tests++;
        if (accepts != w * h || er.size() != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL image_totals %0dx%0d: accepts=%0d left=%0d done=%0d, required %0d 0 1",
                     w, h, accepts, er.size(), done_cnt, w * h);
        end
        if (chk_timing) begin
            n_tests++;
            if (t_done != t_last + 2) begin
                n_fail++;
                $display("FAIL done_latency: got %0d cycles required 2", t_done - t_last);
            end
        end
`ifdef CONV_SCAN_STALL_CNT_EN
        n_tests++;
        if (stall_cnt !== CW'(stalls)) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, stalls);
        end
`endif
    endtask

    task automatic test_full_rate();
        scan_image(4, 4, 100, 100, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_out_stall();
        scan_image(4, 4, 100, 100, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_cfg_err();
        @(negedge clk);
        start = 1'b1; img_w = CW'(2); img_h = CW'(8);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_reject: err=%b busy=%b rdy=%b, required 1 0 0", cfg_err, busy, in_ready);
        end
        scan_image(3, 3, 100, 100, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_start_ignored();
        scan_image(5, 4, 100, 100, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int acc = 0, guard = 0;
        bit saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; img_w = CW'(4); img_h = CW'(4);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        while (acc < 7 && guard < 100) begin
            #1;
            if (pix_en === 1'b1) acc++;
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (acc != 7) begin
            n_fail++;
            $display("FAIL mid_accepts: got %0d required 7", acc);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b ov=%b rdy=%b done=%b, required all 0", busy, out_valid, in_ready, done);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL no_done_after_reset: done/busy seen high, required low");
        end
    endtask

    task automatic test_random_gaps();
        scan_image(5, 6, 60, 50, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            scan_image(int'($urandom_range(3, 7)), int'($urandom_range(3, 7)),
                       int'($urandom_range(30, 90)), int'($urandom_range(30, 90)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        scan_image(3, 4, 100, 100, 1'b0, 1'b0, 1'b1);
        scan_image(4, 3, 100, 70, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_out_stall();
        test_cfg_err();
        test_start_ignored();
        test_reset_mid();
        test_random_gaps();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
